// File: rtl/display_timings.sv
// display_timings
//
// Raster scan generator for the pixel pattern generators and the video
// output stage. Keeps a horizontal and a vertical position counter and
// decodes data-enable, horizontal/vertical sync and line/frame strobes
// from them. The counters advance one pixel on every rising edge of
// i_pix_clk where i_en is high. This lets the block run from a clock
// that is faster than the pixel rate.
//
// Every output is registered and describes the same pixel as the o_x/o_y
// pair presented in the same cycle. Each line is laid out as: active
// pixels, front porch, sync, back porch. Frames use the same order in
// lines.
//
// Ports:
//   i_pix_clk  in   1   pixel clock, the only clock
//   i_rst      in   1   synchronous active-high reset, wins over i_en
//   i_en       in   1   advance strobe, one pixel step per enabled edge
//   o_x        out  13  horizontal position, 0..H_TOTAL-1
//   o_y        out  13  vertical position, 0..V_TOTAL-1
//   o_hs       out  1   horizontal sync, active level H_POL
//   o_vs       out  1   vertical sync, active level V_POL, whole lines
//   o_de       out  1   data enable, high inside the active region
//   o_line     out  1   one-cycle strobe on the first pixel of a line
//   o_frame    out  1   one-cycle strobe on the first pixel of a frame

module display_timings #(
  parameter int H_RES  = 640,
  parameter int V_RES  = 480,
  parameter int H_FP   = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP   = 48,
  parameter int V_FP   = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 33,
  parameter bit H_POL  = 1'b0,
  parameter bit V_POL  = 1'b0
) (
  input  logic        i_pix_clk,
  input  logic        i_rst,
  input  logic        i_en,
  output logic [12:0] o_x,
  output logic [12:0] o_y,
  output logic        o_hs,
  output logic        o_vs,
  output logic        o_de,
  output logic        o_line,
  output logic        o_frame
);

  localparam int H_TOTAL = H_RES + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_RES + V_FP + V_SYNC + V_BP;

  // The counters are 13 bits wide, so a line or a frame longer than
  // 8192 cannot be represented. Negative or empty timings make no sense
  // either. Reject both at elaboration, not at run time.
  generate
    if (H_RES < 1 || H_FP < 0 || H_SYNC < 0 || H_BP < 0 || H_TOTAL > 8192) begin : g_bad_h
      $error("display_timings: horizontal timing parameters out of range");
    end
    if (V_RES < 1 || V_FP < 0 || V_SYNC < 0 || V_BP < 0 || V_TOTAL > 8192) begin : g_bad_v
      $error("display_timings: vertical timing parameters out of range");
    end
  endgenerate

  // The comparisons use a 14-bit domain. With a total of exactly 8192
  // and an empty back porch, the end of sync equals 8192. That value
  // does not fit in the 13-bit position itself.
  localparam logic [13:0] H_LAST       = 14'(H_TOTAL - 1);
  localparam logic [13:0] V_LAST       = 14'(V_TOTAL - 1);
  localparam logic [13:0] H_ACT_END    = 14'(H_RES);
  localparam logic [13:0] V_ACT_END    = 14'(V_RES);
  localparam logic [13:0] H_SYNC_BEG   = 14'(H_RES + H_FP);
  localparam logic [13:0] H_SYNC_END   = 14'(H_RES + H_FP + H_SYNC);
  localparam logic [13:0] V_SYNC_BEG   = 14'(V_RES + V_FP);
  localparam logic [13:0] V_SYNC_END   = 14'(V_RES + V_FP + V_SYNC);
  localparam logic [12:0] X_RESET      = 13'(H_TOTAL - 1);
  localparam logic [12:0] Y_RESET      = 13'(V_TOTAL - 1);

  logic        h_wrap;
  logic        v_wrap;
  logic [12:0] next_x;
  logic [12:0] next_y;
  logic [13:0] nx;
  logic [13:0] ny;
  logic        next_de;
  logic        next_hs;
  logic        next_vs;
  logic        next_line;
  logic        next_frame;

  // Position the counters move to on an enabled edge. The terminal
  // values are matched explicitly, so the counters never wrap through
  // their natural 13-bit range.
  always_comb begin
    h_wrap = ({1'b0, o_x} == H_LAST);
    v_wrap = ({1'b0, o_y} == V_LAST);
    next_x = o_x + 13'd1;
    next_y = o_y;
    if (h_wrap) begin
      next_x = '0;
      next_y = v_wrap ? 13'd0 : o_y + 13'd1;
    end
  end

  // The decode runs on the upcoming position, not the current one. It
  // is registered together with the counters, so sync, DE and the
  // strobes stay aligned with the o_x/o_y shown in the same cycle.
  // vsync depends only on y. Because y only changes when x returns to 0,
  // its edges fall on x=0.
  always_comb begin
    nx         = {1'b0, next_x};
    ny         = {1'b0, next_y};
    next_de    = (nx < H_ACT_END) && (ny < V_ACT_END);
    next_hs    = ((nx >= H_SYNC_BEG) && (nx < H_SYNC_END)) ? H_POL : ~H_POL;
    next_vs    = ((ny >= V_SYNC_BEG) && (ny < V_SYNC_END)) ? V_POL : ~V_POL;
    next_line  = (next_x == 13'd0);
    next_frame = next_line && (next_y == 13'd0);
  end

  // State and output register. Reset parks the scan on the last pixel of
  // the frame. The first enabled tick after reset therefore lands on
  // (0,0) with both strobes raised. On edges without i_en, the position
  // and level outputs hold, but the strobes clear. This keeps each strobe
  // exactly one clock wide, no matter how sparse i_en is.
  always_ff @(posedge i_pix_clk) begin
    if (i_rst) begin
      o_x     <= X_RESET;
      o_y     <= Y_RESET;
      o_de    <= 1'b0;
      o_hs    <= ~H_POL;
      o_vs    <= ~V_POL;
      o_line  <= 1'b0;
      o_frame <= 1'b0;
    end else if (i_en) begin
      o_x     <= next_x;
      o_y     <= next_y;
      o_de    <= next_de;
      o_hs    <= next_hs;
      o_vs    <= next_vs;
      o_line  <= next_line;
      o_frame <= next_frame;
    end else begin
      o_line  <= 1'b0;
      o_frame <= 1'b0;
    end
  end

endmodule

// File: tb/tb_display_timings.sv
// tb_display_timings
//
// Bench for display_timings. It runs three instances from one shared
// clock, reset and enable:
//   dut_vga    default 640x480 timing, active-low syncs
//   dut_small  small geometry (55x39 total), active-low syncs
//   dut_inv    the same small geometry with active-high syncs
// The small geometry makes complete frames affordable.
//
// The reference model knows only how many enabled ticks have happened
// since reset, and whether the last edge was enabled. From those it
// derives the expected pixel by division and remainder over the frame
// size. It then classifies that pixel directly from the timing numbers.

module tb_display_timings;

  localparam int SH_RES  = 40;
  localparam int SH_FP   = 4;
  localparam int SH_SYNC = 6;
  localparam int SH_BP   = 5;
  localparam int SV_RES  = 30;
  localparam int SV_FP   = 3;
  localparam int SV_SYNC = 2;
  localparam int SV_BP   = 4;
  localparam int SH_TOT  = SH_RES + SH_FP + SH_SYNC + SH_BP;
  localparam int SV_TOT  = SV_RES + SV_FP + SV_SYNC + SV_BP;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;

  always #5 clk = ~clk;

  logic [12:0] x0, y0, x1, y1, x2, y2;
  logic hs0, vs0, de0, ln0, fr0;
  logic hs1, vs1, de1, ln1, fr1;
  logic hs2, vs2, de2, ln2, fr2;

  display_timings dut_vga (
    .i_pix_clk(clk), .i_rst(rst), .i_en(en),
    .o_x(x0), .o_y(y0), .o_hs(hs0), .o_vs(vs0), .o_de(de0),
    .o_line(ln0), .o_frame(fr0)
  );

  display_timings #(
    .H_RES(SH_RES), .V_RES(SV_RES), .H_FP(SH_FP), .H_SYNC(SH_SYNC),
    .H_BP(SH_BP), .V_FP(SV_FP), .V_SYNC(SV_SYNC), .V_BP(SV_BP),
    .H_POL(1'b0), .V_POL(1'b0)
  ) dut_small (
    .i_pix_clk(clk), .i_rst(rst), .i_en(en),
    .o_x(x1), .o_y(y1), .o_hs(hs1), .o_vs(vs1), .o_de(de1),
    .o_line(ln1), .o_frame(fr1)
  );

  display_timings #(
    .H_RES(SH_RES), .V_RES(SV_RES), .H_FP(SH_FP), .H_SYNC(SH_SYNC),
    .H_BP(SH_BP), .V_FP(SV_FP), .V_SYNC(SV_SYNC), .V_BP(SV_BP),
    .H_POL(1'b1), .V_POL(1'b1)
  ) dut_inv (
    .i_pix_clk(clk), .i_rst(rst), .i_en(en),
    .o_x(x2), .o_y(y2), .o_hs(hs2), .o_vs(vs2), .o_de(de2),
    .o_line(ln2), .o_frame(fr2)
  );

  int     checks   = 0;
  int     failures = 0;
  longint ticks    = 0;
  bit     last_en  = 1'b0;

  function automatic logic [30:0] observed(int d);
    case (d)
      0:       return {x0, y0, hs0, vs0, de0, ln0, fr0};
      1:       return {x1, y1, hs1, vs1, de1, ln1, fr1};
      default: return {x2, y2, hs2, vs2, de2, ln2, fr2};
    endcase
  endfunction

  function automatic logic [30:0] expected(int d);
    int hres, hfp, hsync, hbp, vres, vfp, vsync, vbp;
    bit hpol, vpol;
    longint htot, vtot, p;
    int x, y;
    bit hs, vs, de, ln, fr;
    if (d == 0) begin
      hres = 640; hfp = 16; hsync = 96; hbp = 48;
      vres = 480; vfp = 10; vsync = 2;  vbp = 33;
      hpol = 1'b0; vpol = 1'b0;
    end else begin
      hres = SH_RES; hfp = SH_FP; hsync = SH_SYNC; hbp = SH_BP;
      vres = SV_RES; vfp = SV_FP; vsync = SV_SYNC; vbp = SV_BP;
      hpol = (d == 2); vpol = (d == 2);
    end
    htot = longint'(hres + hfp + hsync + hbp);
    vtot = longint'(vres + vfp + vsync + vbp);
    if (ticks == 0) begin
      x = int'(htot - 1); y = int'(vtot - 1);
      de = 1'b0; hs = ~hpol; vs = ~vpol; ln = 1'b0; fr = 1'b0;
    end else begin
      p  = (ticks - 1) % (htot * vtot);
      x  = int'(p % htot);
      y  = int'(p / htot);
      de = (x < hres) && (y < vres);
      hs = (x >= hres + hfp && x < hres + hfp + hsync) ? hpol : ~hpol;
      vs = (y >= vres + vfp && y < vres + vfp + vsync) ? vpol : ~vpol;
      ln = last_en && (x == 0);
      fr = ln && (y == 0);
    end
    return {13'(x), 13'(y), hs, vs, de, ln, fr};
  endfunction

  // One clock: drive the inputs, take the edge, update the model and
  // settle 1 time unit past the edge for sampling.
  task automatic step(input bit e, input bit r);
    en  = e;
    rst = r;
    @(posedge clk);
    if (r) begin
      ticks   = 0;
      last_en = 1'b0;
    end else begin
      if (e) ticks++;
      last_en = e;
    end
    #1;
  endtask

  task automatic test_reset();
    step(1'b1, 1'b1);
    step(1'($urandom_range(0, 1)), 1'b1);
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (observed(d) !== expected(d)) begin
        failures++;
        $display("[TB] FAIL reset_model dut=%0d got=%h exp=%h", d, observed(d), expected(d));
      end
    end
    checks++;
    if ({x0, y0, de0, hs0, vs0, ln0, fr0} !== {13'd799, 13'd524, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0}) begin
      failures++;
      $display("[TB] FAIL reset_vga got x=%0d y=%0d de=%b hs=%b vs=%b ln=%b fr=%b exp 799 524 0 1 1 0 0",
               x0, y0, de0, hs0, vs0, ln0, fr0);
    end
    checks++;
    if ({hs2, vs2} !== 2'b00) begin
      failures++;
      $display("[TB] FAIL reset_inv_sync got hs=%b vs=%b exp 0 0", hs2, vs2);
    end
  endtask

  task automatic test_first_ticks();
    step(1'b1, 1'b0);
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (observed(d) !== expected(d)) begin
        failures++;
        $display("[TB] FAIL first_tick_model dut=%0d got=%h exp=%h", d, observed(d), expected(d));
      end
    end
    checks++;
    if ({x0, y0, de0, ln0, fr0} !== {13'd0, 13'd0, 1'b1, 1'b1, 1'b1}) begin
      failures++;
      $display("[TB] FAIL first_tick got x=%0d y=%0d de=%b ln=%b fr=%b exp 0 0 1 1 1", x0, y0, de0, ln0, fr0);
    end
    step(1'b1, 1'b0);
    checks++;
    if ({x0, ln0, fr0} !== {13'd1, 1'b0, 1'b0}) begin
      failures++;
      $display("[TB] FAIL second_tick got x=%0d ln=%b fr=%b exp 1 0 0", x0, ln0, fr0);
    end
  endtask

  // Runs from x=1 to x=799 of line 0 on the VGA instance.
  task automatic test_hsync_line0();
    int hs_cnt = 0;
    int de_cnt = 0;
    int first_x = -1;
    int last_x = -1;
    int guard = 0;
    if (de0 === 1'b1) de_cnt++;
    while (x0 !== 13'd799 && guard < 1000) begin
      step(1'b1, 1'b0);
      guard++;
      for (int d = 0; d < 3; d++) begin
        checks++;
        if (observed(d) !== expected(d)) begin
          failures++;
          $display("[TB] FAIL hsync_model dut=%0d got=%h exp=%h", d, observed(d), expected(d));
        end
      end
      if (hs0 === 1'b0) begin
        hs_cnt++;
        if (first_x < 0) first_x = int'(x0);
        last_x = int'(x0);
      end
      if (de0 === 1'b1) de_cnt++;
    end
    checks++;
    if (guard >= 1000) begin
      failures++;
      $display("[TB] FAIL hsync_timeout got x=%0d exp 799", x0);
    end
    checks++;
    if (hs_cnt != 96 || first_x != 656 || last_x != 751) begin
      failures++;
      $display("[TB] FAIL hsync_window got cnt=%0d first=%0d last=%0d exp 96 656 751", hs_cnt, first_x, last_x);
    end
    // x=0 was already passed in test_first_ticks, so 639 remain here.
    checks++;
    if (de_cnt != 639) begin
      failures++;
      $display("[TB] FAIL de_line0 got=%0d exp=639", de_cnt);
    end
  endtask

  task automatic test_line_wrap();
    int guard = 0;
    while (!(x0 === 13'd799 && y0 === 13'd3) && guard < 4000) begin
      step(1'b1, 1'b0);
      guard++;
      for (int d = 0; d < 3; d++) begin
        checks++;
        if (observed(d) !== expected(d)) begin
          failures++;
          $display("[TB] FAIL line_wrap_model dut=%0d got=%h exp=%h", d, observed(d), expected(d));
        end
      end
    end
    step(1'b1, 1'b0);
    checks++;
    if ({x0, y0, ln0, fr0} !== {13'd0, 13'd4, 1'b1, 1'b0}) begin
      failures++;
      $display("[TB] FAIL line_wrap got x=%0d y=%0d ln=%b fr=%b exp 0 4 1 0", x0, y0, ln0, fr0);
    end
  endtask

  // One complete small frame with random enable gaps.
  task automatic test_small_frame();
    int steps = 0, lines = 0, frames = 0, des = 0, vs_lo = 0, vs_hi_inv = 0;
    int guard = 0;
    bit e;
    step(1'b1, 1'b1);
    while (ticks < longint'(SH_TOT * SV_TOT) && guard < 20000) begin
      e = ($urandom_range(0, 3) != 0);
      step(e, 1'b0);
      guard++;
      for (int d = 0; d < 3; d++) begin
        checks++;
        if (observed(d) !== expected(d)) begin
          failures++;
          $display("[TB] FAIL frame_model dut=%0d got=%h exp=%h", d, observed(d), expected(d));
        end
      end
      if (ln1 === 1'b1) lines++;
      if (fr1 === 1'b1) frames++;
      if (e) begin
        steps++;
        if (de1 === 1'b1) des++;
        if (vs1 === 1'b0) vs_lo++;
        if (vs2 === 1'b1) vs_hi_inv++;
      end
    end
    checks++;
    if (guard >= 20000) begin
      failures++;
      $display("[TB] FAIL frame_timeout got ticks=%0d exp %0d", ticks, SH_TOT * SV_TOT);
    end
    checks++;
    if (steps != SH_TOT * SV_TOT || lines != SV_TOT || frames != 1) begin
      failures++;
      $display("[TB] FAIL frame_counts got steps=%0d lines=%0d frames=%0d exp %0d %0d 1",
               steps, lines, frames, SH_TOT * SV_TOT, SV_TOT);
    end
    checks++;
    if (des != SH_RES * SV_RES || vs_lo != SV_SYNC * SH_TOT || vs_hi_inv != SV_SYNC * SH_TOT) begin
      failures++;
      $display("[TB] FAIL frame_de_vs got de=%0d vs=%0d vs_inv=%0d exp %0d %0d %0d",
               des, vs_lo, vs_hi_inv, SH_RES * SV_RES, SV_SYNC * SH_TOT, SV_SYNC * SH_TOT);
    end
  endtask

  task automatic test_enable_gating();
    bit pattern [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [30:0] want [4];
    step(1'b1, 1'b1);
    for (int i = 0; i < SH_TOT * SV_TOT; i++) step(1'b1, 1'b0);
    checks++;
    if ({x1, y1} !== {13'(SH_TOT - 1), 13'(SV_TOT - 1)}) begin
      failures++;
      $display("[TB] FAIL gating_setup got x=%0d y=%0d exp %0d %0d", x1, y1, SH_TOT - 1, SV_TOT - 1);
    end
    // x, y, hs, vs, de, line, frame for the small instance
    want[0] = {13'd0, 13'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    want[1] = {13'd0, 13'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    want[2] = {13'd0, 13'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    want[3] = {13'd1, 13'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++) begin
      step(pattern[i], 1'b0);
      checks++;
      if (observed(1) !== want[i]) begin
        failures++;
        $display("[TB] FAIL gating_step%0d got=%h exp=%h", i, observed(1), want[i]);
      end
      for (int d = 0; d < 3; d++) begin
        checks++;
        if (observed(d) !== expected(d)) begin
          failures++;
          $display("[TB] FAIL gating_model dut=%0d got=%h exp=%h", d, observed(d), expected(d));
        end
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    step(1'b1, 1'b1);
    for (int i = 0; i < 20 * SH_TOT + 23 + 1; i++) step(1'b1, 1'b0);
    checks++;
    if ({x1, y1} !== {13'd23, 13'd20}) begin
      failures++;
      $display("[TB] FAIL mid_setup got x=%0d y=%0d exp 23 20", x1, y1);
    end
    step(1'b1, 1'b1);
    checks++;
    if ({x1, y1, de1, hs1, vs1, ln1, fr1, hs2, vs2, x0, y0} !==
        {13'(SH_TOT - 1), 13'(SV_TOT - 1), 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 13'd799, 13'd524}) begin
      failures++;
      $display("[TB] FAIL mid_reset got x=%0d y=%0d de=%b hs=%b vs=%b inv_hs=%b inv_vs=%b vga=(%0d,%0d)",
               x1, y1, de1, hs1, vs1, hs2, vs2, x0, y0);
    end
    step(1'b1, 1'b0);
    checks++;
    if ({x1, y1, fr1, x0, y0, fr0} !== {13'd0, 13'd0, 1'b1, 13'd0, 13'd0, 1'b1}) begin
      failures++;
      $display("[TB] FAIL mid_release got small=(%0d,%0d,fr=%b) vga=(%0d,%0d,fr=%b) exp (0,0,1)",
               x1, y1, fr1, x0, y0, fr0);
    end
    for (int i = 0; i < SH_RES + SH_FP; i++) step(1'b1, 1'b0);
    checks++;
    if ({x1, hs1, hs2} !== {13'(SH_RES + SH_FP), 1'b0, 1'b1}) begin
      failures++;
      $display("[TB] FAIL inv_hsync got x=%0d hs=%b inv_hs=%b exp %0d 0 1", x1, hs1, hs2, SH_RES + SH_FP);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 4000; i++) begin
      step(($urandom_range(0, 3) != 0), ($urandom_range(0, 499) == 0));
      for (int d = 0; d < 3; d++) begin
        checks++;
        if (observed(d) !== expected(d)) begin
          failures++;
          $display("[TB] FAIL random_model dut=%0d got=%h exp=%h tick=%0d", d, observed(d), expected(d), ticks);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_ticks();
    test_hsync_line0();
    test_line_wrap();
    test_small_frame();
    test_enable_gating();
    test_reset_mid_frame();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
